// File: rtl/ysyx_23060332_wbu_pkg.sv
// Shared definitions for the write-back unit: FSM state encoding,
// load funct3 codes and default datapath widths.
package ysyx_23060332_wbu_pkg;

    localparam int WBU_XLEN = 32;
    localparam int WBU_RA_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_WB   = 2'd3
    } wbu_state_e;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

endpackage

// File: rtl/ysyx_23060332_load_align.sv
// Combinational load alignment: selects the byte/halfword addressed by the
// low address bits, extends it, and flags illegal or misaligned loads.
module ysyx_23060332_load_align
    import ysyx_23060332_wbu_pkg::*;
#(
    parameter int XLEN = WBU_XLEN
) (
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_offset,
    input  logic [XLEN-1:0] i_word,
    output logic [XLEN-1:0] o_data,
    output logic            o_err
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[{i_offset, 3'b000} +: 8];
        w_half = i_word[{i_offset[1], 4'b0000} +: 16];
        o_data = '0;
        o_err  = 1'b0;
        unique case (i_funct3)
            F3_LB:  o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_LBU: o_data = {{(XLEN-8){1'b0}}, w_byte};
            F3_LH: begin
                o_data = {{(XLEN-16){w_half[15]}}, w_half};
                o_err  = i_offset[0];
            end
            F3_LHU: begin
                o_data = {{(XLEN-16){1'b0}}, w_half};
                o_err  = i_offset[0];
            end
            F3_LW: begin
                o_data = i_word;
                o_err  = (i_offset != 2'b00);
            end
            default: o_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/ysyx_23060332_wbu.sv
// Write-back unit: retires one EXU instruction at a time, performs the
// single-word memory read for loads, and drives the register-file write port.
module ysyx_23060332_wbu
    import ysyx_23060332_wbu_pkg::*;
#(
    parameter int XLEN = WBU_XLEN,
    parameter int RA_W = WBU_RA_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [RA_W-1:0] in_rd,
    input  logic [XLEN-1:0] in_result,
    input  logic            in_rf_wen,
    input  logic            in_is_load,
    input  logic [2:0]      in_funct3,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [RA_W-1:0] waddr,
    output logic [XLEN-1:0] wdata,
    output logic            reg_wen,
    output logic            commit,
    output logic            load_err
);

    wbu_state_e      r_state, w_next;
    logic [RA_W-1:0] r_rd;
    logic [XLEN-1:0] r_result;
    logic [XLEN-1:0] r_wb_data;
    logic            r_rf_wen;
    logic [2:0]      r_funct3;
    logic            r_err;

    logic [2:0]      w_al_funct3;
    logic [1:0]      w_al_offset;
    logic [XLEN-1:0] w_al_data;
    logic            w_al_err;

    // One aligner serves both the IDLE legality check (incoming fields) and
    // the WAIT data extraction (captured fields).
    assign w_al_funct3 = (r_state == ST_IDLE) ? in_funct3 : r_funct3;
    assign w_al_offset = (r_state == ST_IDLE) ? in_result[1:0] : r_result[1:0];

    ysyx_23060332_load_align #(.XLEN(XLEN)) u_align (
        .i_funct3 (w_al_funct3),
        .i_offset (w_al_offset),
        .i_word   (mem_rdata),
        .o_data   (w_al_data),
        .o_err    (w_al_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_rd      <= '0;
            r_result  <= '0;
            r_wb_data <= '0;
            r_rf_wen  <= 1'b0;
            r_funct3  <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && in_valid) begin
                r_rd      <= in_rd;
                r_result  <= in_result;
                r_wb_data <= in_result;
                r_rf_wen  <= in_rf_wen;
                r_funct3  <= in_funct3;
                r_err     <= in_is_load && w_al_err;
            end
            if (r_state == ST_WAIT && mem_rsp_valid) begin
                r_wb_data <= w_al_data;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_next = (in_is_load && !w_al_err) ? ST_REQ : ST_WB;
                end
            end
            ST_REQ:  if (mem_req_ready) w_next = ST_WAIT;
            ST_WAIT: if (mem_rsp_valid) w_next = ST_WB;
            ST_WB:   w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready      = (r_state == ST_IDLE);
        mem_req_valid = (r_state == ST_REQ);
        mem_addr      = {r_result[XLEN-1:2], 2'b00};
        waddr         = r_rd;
        wdata         = r_wb_data;
        commit        = (r_state == ST_WB);
        reg_wen       = (r_state == ST_WB) && r_rf_wen && (r_rd != '0) && !r_err;
        load_err      = (r_state == ST_WB) && r_err;
    end

endmodule

// File: tb/tb_ysyx_23060332_wbu.sv
// Self-checking bench for the write-back unit with a queue-based scoreboard
// of expected retirements.
module tb_ysyx_23060332_wbu;

    logic        clk, rst;
    logic        in_valid, in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_result;
    logic        in_rf_wen, in_is_load;
    logic [2:0]  in_funct3;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        reg_wen, commit, load_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        wen;
        logic        err;
    } exp_t;

    exp_t sb[$];

    ysyx_23060332_wbu #(.XLEN(32), .RA_W(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rd         (in_rd),
        .in_result     (in_result),
        .in_rf_wen     (in_rf_wen),
        .in_is_load    (in_is_load),
        .in_funct3     (in_funct3),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata),
        .waddr         (waddr),
        .wdata         (wdata),
        .reg_wen       (reg_wen),
        .commit        (commit),
        .load_err      (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction for a single IDLE cycle and drops in_valid.
    task automatic issue(input logic [4:0] rd, input logic [31:0] res, input logic wen,
                         input logic ld, input logic [2:0] f3);
        in_valid = 1'b1; in_rd = rd; in_result = res;
        in_rf_wen = wen; in_is_load = ld; in_funct3 = f3;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1; in_rd = 5'd9; in_result = 32'h1111_2222;
        in_rf_wen = 1'b1; in_is_load = 1'b0; in_funct3 = 3'd0;
        tick(); tick();
        rst = 1'b0;
        in_valid = 1'b0;
        total++;
        if ({in_ready, mem_req_valid, commit, reg_wen, load_err} !== 5'b10000) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 10000",
                     {in_ready, mem_req_valid, commit, reg_wen, load_err});
        end
        tick();
        total++;
        if (commit !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_wins_handshake: got commit=%b in_ready=%b want 0 1", commit, in_ready);
        end
    endtask

    task automatic test_alu();
        exp_t tbl [4];
        exp_t e;
        tbl = '{'{5'd5,  32'h1234_5678, 1'b1, 1'b0},
                '{5'd0,  32'hFFFF_FFFF, 1'b1, 1'b0},
                '{5'd7,  32'h0000_DEAD, 1'b0, 1'b0},
                '{5'd31, 32'h8000_0001, 1'b1, 1'b0}};
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{tbl[i].rd, tbl[i].data, tbl[i].wen && (tbl[i].rd != 5'd0), 1'b0});
            issue(tbl[i].rd, tbl[i].data, tbl[i].wen, 1'b0, 3'd0);
            e = sb.pop_front();
            total++;
            if (commit !== 1'b1 || reg_wen !== e.wen || load_err !== 1'b0 || mem_req_valid !== 1'b0 ||
                (e.wen && (waddr !== e.rd || wdata !== e.data))) begin
                bad++;
                $display("FAIL alu_%0d: got commit=%b wen=%b err=%b waddr=%0d wdata=%h want 1 %b 0 %0d %h",
                         i, commit, reg_wen, load_err, waddr, wdata, e.wen, e.rd, e.data);
            end
            tick();
        end
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [31:0] exp;
    } ld_t;

    task automatic test_loads();
        ld_t  tbl [7];
        exp_t e;
        tbl = '{'{3'd0, 32'h8000_0003, 32'h80AA_BBCC, 32'hFFFF_FF80},
                '{3'd4, 32'h8000_0003, 32'h80AA_BBCC, 32'h0000_0080},
                '{3'd0, 32'h8000_0001, 32'h80AA_BBCC, 32'hFFFF_FFBB},
                '{3'd4, 32'h8000_0002, 32'h80AA_BBCC, 32'h0000_00AA},
                '{3'd1, 32'h8000_0000, 32'h8001_7FFF, 32'h0000_7FFF},
                '{3'd5, 32'h8000_0002, 32'h8001_7FFF, 32'h0000_8001},
                '{3'd2, 32'h8000_0004, 32'hCAFE_F00D, 32'hCAFE_F00D}};
        for (int i = 0; i < 7; i++) begin
            sb.push_back('{5'd3 + 5'(i), tbl[i].exp, 1'b1, 1'b0});
            issue(5'd3 + 5'(i), tbl[i].addr, 1'b1, 1'b1, tbl[i].f3);
            total++;
            if (mem_req_valid !== 1'b1 || mem_addr !== {tbl[i].addr[31:2], 2'b00}) begin
                bad++;
                $display("FAIL load_req_%0d: got valid=%b addr=%h want 1 %h",
                         i, mem_req_valid, mem_addr, {tbl[i].addr[31:2], 2'b00});
            end
            mem_req_ready = 1'b1;
            tick();
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b1; mem_rdata = tbl[i].rdata;
            tick();
            mem_rsp_valid = 1'b0; mem_rdata = 32'hDEAD_BEEF;
            e = sb.pop_front();
            total++;
            if (commit !== 1'b1 || reg_wen !== 1'b1 || load_err !== 1'b0 ||
                waddr !== e.rd || wdata !== e.data) begin
                bad++;
                $display("FAIL load_wb_%0d: got commit=%b wen=%b err=%b waddr=%0d wdata=%h want 1 1 0 %0d %h",
                         i, commit, reg_wen, load_err, waddr, wdata, e.rd, e.data);
            end
            tick();
        end
    endtask

    task automatic test_lh_stall();
        exp_t e;
        logic ok;
        sb.push_back('{5'd12, 32'hFFFF_8001, 1'b1, 1'b0});
        issue(5'd12, 32'h8000_0002, 1'b1, 1'b1, 3'd1);
        ok = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_0000 || in_ready !== 1'b0 || commit !== 1'b0)
                ok = 1'b0;
            tick();
        end
        mem_req_ready = 1'b1;
        if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_0000) ok = 1'b0;
        tick();
        mem_req_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            if (mem_req_valid !== 1'b0 || in_ready !== 1'b0 || commit !== 1'b0) ok = 1'b0;
            tick();
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL lh_stall_hold: got unstable req/in_ready/commit during stall want stable req, in_ready=0");
        end
        mem_rsp_valid = 1'b1; mem_rdata = 32'h8001_7FFF;
        tick();
        mem_rsp_valid = 1'b0;
        e = sb.pop_front();
        total++;
        if (commit !== 1'b1 || reg_wen !== 1'b1 || waddr !== e.rd || wdata !== e.data || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL lh_stall_wb: got commit=%b wen=%b waddr=%0d wdata=%h in_ready=%b want 1 1 %0d %h 0",
                     commit, reg_wen, waddr, wdata, in_ready, e.rd, e.data);
        end
        tick();
    endtask

    task automatic test_load_err();
        logic [2:0]  f3s   [6];
        logic [31:0] addrs [6];
        exp_t e;
        f3s   = '{3'd2, 3'd3, 3'd1, 3'd5, 3'd6, 3'd2};
        addrs = '{32'h8000_0001, 32'h8000_0000, 32'h8000_0003,
                  32'h8000_0001, 32'h8000_0000, 32'h8000_0002};
        for (int i = 0; i < 6; i++) begin
            sb.push_back('{5'd4, 32'h0, 1'b0, 1'b1});
            issue(5'd4, addrs[i], 1'b1, 1'b1, f3s[i]);
            e = sb.pop_front();
            total++;
            if (mem_req_valid !== 1'b0 || commit !== 1'b1 || reg_wen !== e.wen || load_err !== e.err) begin
                bad++;
                $display("FAIL load_err_%0d: got req=%b commit=%b wen=%b err=%b want 0 1 %b %b",
                         i, mem_req_valid, commit, reg_wen, load_err, e.wen, e.err);
            end
            tick();
            total++;
            if (load_err !== 1'b0 || commit !== 1'b0 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL load_err_pulse_%0d: got err=%b commit=%b in_ready=%b want 0 0 1",
                         i, load_err, commit, in_ready);
            end
        end
    endtask

    task automatic test_rst_in_wait();
        logic ok;
        issue(5'd6, 32'h8000_0000, 1'b1, 1'b1, 3'd2);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (mem_req_valid !== 1'b0 || in_ready !== 1'b1 || commit !== 1'b0 || reg_wen !== 1'b0) begin
            bad++;
            $display("FAIL rst_in_wait: got req=%b in_ready=%b commit=%b wen=%b want 0 1 0 0",
                     mem_req_valid, in_ready, commit, reg_wen);
        end
        mem_rsp_valid = 1'b1; mem_rdata = 32'h1234_5678;
        ok = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            mem_rsp_valid = 1'b0;
            if (commit !== 1'b0 || reg_wen !== 1'b0 || in_ready !== 1'b1) ok = 1'b0;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL late_rsp_ignored: got a commit/write after abandoned load want none");
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        in_valid = 1'b1; in_rf_wen = 1'b1; in_is_load = 1'b0; in_funct3 = 3'd0;
        for (int i = 0; i < 3; i++) begin
            in_rd = 5'd20 + 5'(i); in_result = 32'hA000_0000 + 32'(i);
            sb.push_back('{in_rd, in_result, 1'b1, 1'b0});
            tick();
            e = sb.pop_front();
            total++;
            if (commit !== 1'b1 || reg_wen !== 1'b1 || waddr !== e.rd || wdata !== e.data || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL b2b_%0d: got commit=%b wen=%b waddr=%0d wdata=%h in_ready=%b want 1 1 %0d %h 0",
                         i, commit, reg_wen, waddr, wdata, in_ready, e.rd, e.data);
            end
            tick();
            total++;
            if (commit !== 1'b0 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL b2b_gap_%0d: got commit=%b in_ready=%b want 0 1", i, commit, in_ready);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_result = '0;
        in_rf_wen = 1'b0; in_is_load = 1'b0; in_funct3 = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
        test_reset();
        test_alu();
        test_loads();
        test_lh_stall();
        test_load_err();
        test_rst_in_wait();
        test_back_to_back();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d leftover want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
